csa_slice_sequencer: RTL
========================

CSA_SLICE_SEQUENCER -- requirements
Module: csa_slice_sequencer

Interface
REQ-001 Parameter NSLICE, default 4: number of 4-bit slices per operand; operand width W = 4*NSLICE.
REQ-002 Parameter ADDER_LAT, default 1: cycles from slice drive to valid slice_s/slice_cout (legal values 0 or 1).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  operand pair offered.
REQ-006 in_ready  out  1  block accepts operands.
REQ-007 in_a  in  W  operand A.
REQ-008 in_b  in  W  operand B.
REQ-009 in_cin  in  1  carry into slice 0.
REQ-010 slice_a  out  4  A slice driven to the carry-select adder.
REQ-011 slice_b  out  4  B slice driven to the carry-select adder.
REQ-012 slice_cin  out  1  carry driven to the carry-select adder.
REQ-013 slice_s  in  4  adder sum for the driven slice.
REQ-014 slice_cout  in  1  adder carry-out for the driven slice.
REQ-015 out_valid  out  1  result available.
REQ-016 out_ready  in  1  consumer accepts result.
REQ-017 out_sum  out  W  assembled sum.
REQ-018 out_cout  out  1  carry-out of the top slice.

Function
REQ-019 FSM states IDLE, DRIVE, WAIT, DONE; WAIT is entered only when ADDER_LAT=1.
REQ-020 IDLE: in_ready=1; in_valid&in_ready captures in_a, in_b, in_cin, clears slice index k to 0, and moves to DRIVE.
REQ-021 in_ready SHALL be 0 in every state except IDLE; in_valid is ignored outside IDLE.
REQ-022 DRIVE/WAIT: slice_a=a[4k+3:4k], slice_b=b[4k+3:4k], slice_cin=carry register (in_cin for k=0); all are held constant through WAIT.
REQ-023 Capture point: last cycle of slice k (DRIVE if ADDER_LAT=0, WAIT if ADDER_LAT=1) stores slice_s into sum[4k+3:4k] and slice_cout into the carry register.
REQ-024 After capture, k<NSLICE-1 increments k and goes to DRIVE; k=NSLICE-1 goes to DONE.
REQ-025 Latency from the accept edge to out_valid high: exactly NSLICE*(1+ADDER_LAT) cycles (8 at defaults); no slice overlap.
REQ-026 DONE: out_valid=1; out_sum/out_cout stay stable until out_valid&out_ready, then move to IDLE.
REQ-027 out_ready high on the first DONE cycle releases the result in one cycle; the next accept is possible on the following cycle.
REQ-028 Outside DRIVE/WAIT, slice_a, slice_b and slice_cin SHALL be 0.
REQ-029 out_sum/out_cout hold the last result outside DONE; out_valid=0 outside DONE.
REQ-030 The arithmetic result SHALL equal {out_cout,out_sum} = in_a + in_b + in_cin modulo 2^(W+1).

Reset
REQ-031 rst asserted forces IDLE immediately, asynchronously; k=0, carry=0, sum=0, out_sum=0, out_cout=0, out_valid=0, slice outputs 0, in_ready=1 after deassertion.
REQ-032 rst mid-operation aborts the operation; no partial result is presented; the first post-reset accept starts clean.

Structure
REQ-033 Shared package csa_pkg holds SLICE_W=4, the FSM state enum, and the default NSLICE/ADDER_LAT.
REQ-034 No sub-module: the carry-select adder is instantiated beside this block at top level, with slice_* ports wired to its A, B, cin, S and cout.

Verification
REQ-035 Defaults, 0xFFFF+0x0001, cin=0 -> out_sum=0x0000, out_cout=1, out_valid 8 cycles after accept.
REQ-036 0x1234+0x4321, cin=1 -> out_sum=0x5556, out_cout=0; slice_cin observed as 1,0,0,0 across slices.
REQ-037 out_ready held low 5 cycles in DONE -> out_sum/out_valid stable, in_ready=0, a second in_valid is not accepted until release.
REQ-038 rst pulsed during slice 2 of 0xAAAA+0x5555 -> all outputs 0 at once; a subsequent 0x0001+0x0001 yields 0x0002, cout 0.
REQ-039 ADDER_LAT=0, 0x8000+0x8000 -> out_sum=0x0000, out_cout=1, latency 4 cycles.
REQ-040 Back-to-back operations with out_ready tied high -> one result per NSLICE*(1+ADDER_LAT)+2 cycles, each matching REQ-030.

Source files
------------

// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// Module : csa_pkg
// Brief  : Shared constants and FSM state type for the CSA slice sequencer.
// Rev    : 1.0
// ============================================================================
package csa_pkg;

    localparam int SLICE_W           = 4;
    localparam int DEFAULT_NSLICE    = 4;
    localparam int DEFAULT_ADDER_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/csa_slice_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : csa_slice_sequencer_if
// Brief  : Operand/result handshakes plus the slice bus to the external adder.
// Rev    : 1.0
// ============================================================================
interface csa_slice_sequencer_if #(
    parameter int NSLICE = csa_pkg::DEFAULT_NSLICE
) ();
    import csa_pkg::*;

    localparam int W = NSLICE * SLICE_W;

    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_a;
    logic [W-1:0]       in_b;
    logic               in_cin;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic               slice_cin;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_sum;
    logic               out_cout;

    // slave is the sequencer; master is everything around it (source, adder, sink)
    modport slave (
        input  in_valid, in_a, in_b, in_cin, slice_s, slice_cout, out_ready,
        output in_ready, slice_a, slice_b, slice_cin, out_valid, out_sum, out_cout
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, slice_s, slice_cout, out_ready,
        input  in_ready, slice_a, slice_b, slice_cin, out_valid, out_sum, out_cout
    );

endinterface
`default_nettype wire

// File: rtl/csa_slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module : csa_slice_sequencer
// Brief  : Walks a W-bit add through an external 4-bit carry-select adder,
//          one slice at a time, rippling the carry through a register.
// Rev    : 1.0
// ============================================================================
module csa_slice_sequencer
    import csa_pkg::*;
#(
    parameter int NSLICE    = DEFAULT_NSLICE,
    parameter int ADDER_LAT = DEFAULT_ADDER_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    csa_slice_sequencer_if.slave  bus
);

    localparam int            W      = NSLICE * SLICE_W;
    localparam int            KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [W-1:0]  out_sum_q, out_sum_d;
    logic          carry_q, carry_d;
    logic          out_cout_q, out_cout_d;
    logic          slice_active;
    logic          capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            out_sum_q  <= '0;
            carry_q    <= 1'b0;
            out_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            out_sum_q  <= out_sum_d;
            carry_q    <= carry_d;
            out_cout_q <= out_cout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        out_sum_d  = out_sum_q;
        carry_d    = carry_q;
        out_cout_d = out_cout_q;

        slice_active = (state_q == ST_DRIVE) || (state_q == ST_WAIT);
        // With a zero-latency adder the slice result is already valid while driving
        capture      = ((state_q == ST_DRIVE) && (ADDER_LAT == 0)) || (state_q == ST_WAIT);

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    sum_d   = '0;
                    k_d     = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (ADDER_LAT != 0) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_WAIT;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            sum_d[int'(k_q) * SLICE_W +: SLICE_W] = bus.slice_s;
            carry_d = bus.slice_cout;
            if (k_q == K_LAST) begin
                out_sum_d  = sum_d;
                out_cout_d = bus.slice_cout;
                state_d    = ST_DONE;
            end else begin
                k_d     = k_q + KW'(1);
                state_d = ST_DRIVE;
            end
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.slice_a   = slice_active ? a_q[int'(k_q) * SLICE_W +: SLICE_W] : '0;
    assign bus.slice_b   = slice_active ? b_q[int'(k_q) * SLICE_W +: SLICE_W] : '0;
    assign bus.slice_cin = slice_active ? carry_q : 1'b0;

endmodule
`default_nettype wire
